// File: rtl/inst_queue_if.sv
// Handshake bundle between the fetch stage, the instruction queue and the decode stage.
// The queue takes the slave modport; the fetch/decode side (or a bench) drives the master side.
interface inst_queue_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              push_valid;
   logic [ADDR_W-1:0] push_pc;
   logic [INST_W-1:0] push_inst;
   logic              push_ready;
   logic              pop_valid;
   logic [ADDR_W-1:0] pop_pc;
   logic [INST_W-1:0] pop_inst;
   logic              pop_ready;
   logic [CNT_W-1:0]  count;

   modport master (
      output push_valid, push_pc, push_inst, pop_ready,
      input  push_ready, pop_valid, pop_pc, pop_inst, count
   );

   modport slave (
      input  push_valid, push_pc, push_inst, pop_ready,
      output push_ready, pop_valid, pop_pc, pop_inst, count
   );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between IF and ID with flush on branch interception.
// Define INST_QUEUE_BYPASS_EN to let an entry pass straight through an empty queue.
module inst_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input logic         clk,
   input logic         rst,
   input logic         flush,
   inst_queue_if.slave q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic              pop_valid_c;
   logic [ADDR_W-1:0] pop_pc_c;
   logic [INST_W-1:0] pop_inst_c;
   logic              bypass_c;
   logic              pop_fire_c;
   logic              push_ready_c;
   logic              push_fire_c;
   logic              pass_thru_c;
   logic              wr_en_c;
   logic              rd_en_c;
   logic              mem_we_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Head presentation; unstored slots are masked to a zero bubble
   always_comb begin
      pop_valid_c = (cnt_q != '0);
      pop_pc_c    = '0;
      pop_inst_c  = '0;
      bypass_c    = 1'b0;
      if (pop_valid_c) begin
         pop_pc_c   = pc_mem_q[head_q];
         pop_inst_c = inst_mem_q[head_q];
      end
`ifdef INST_QUEUE_BYPASS_EN
      if ((cnt_q == '0) && q.push_valid) begin
         bypass_c    = 1'b1;
         pop_valid_c = 1'b1;
         pop_pc_c    = q.push_pc;
         pop_inst_c  = q.push_inst;
      end
`endif
   end

   // A full queue still accepts when the head leaves in the same cycle
   always_comb begin
      pop_fire_c   = pop_valid_c & q.pop_ready;
      push_ready_c = (cnt_q < CNT_W'(DEPTH)) | pop_fire_c;
      push_fire_c  = q.push_valid & push_ready_c;
      pass_thru_c  = bypass_c & pop_fire_c;
      wr_en_c      = push_fire_c & ~pass_thru_c;
      rd_en_c      = pop_fire_c & ~pass_thru_c;
      mem_we_c     = wr_en_c & ~flush & rst;
   end

   // Pointer/occupancy next state; flush discards same-cycle push and pop
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (wr_en_c) tail_d = ptr_inc(tail_q);
         if (rd_en_c) head_d = ptr_inc(head_q);
         unique case ({wr_en_c, rd_en_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is never reset; reads are masked while empty
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         pc_mem_q[tail_q]   <= q.push_pc;
         inst_mem_q[tail_q] <= q.push_inst;
      end
   end

   assign q.push_ready = push_ready_c;
   assign q.pop_valid  = pop_valid_c;
   assign q.pop_pc     = pop_pc_c;
   assign q.pop_inst   = pop_inst_c;
   assign q.count      = cnt_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed and random checks of inst_queue against a queue-based reference model.
module tb_inst_queue;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned D  = 4;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   inst_queue_if #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) bus ();

   inst_queue #(.ADDR_W(AW), .INST_W(IW), .DEPTH(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   ent_t        mq[$];
   logic [31:0] popped[$];
   logic        obs_pv, obs_pr;
   logic [31:0] obs_pc, obs_inst;
   int          obs_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, compare outputs with the model, advance model at posedge
   task automatic step(input logic r, input logic f, input logic pv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic pr);
      logic        e_pv, e_pr, e_pop, e_push, thru;
      logic [31:0] e_pc, e_inst;
      @(negedge clk);
      rst = r;
      flush = f;
      bus.push_valid = pv;
      bus.push_pc = pc;
      bus.push_inst = inst;
      bus.pop_ready = pr;
      #1;
      thru   = 1'b0;
      e_pv   = (mq.size() != 0);
      e_pc   = e_pv ? mq[0].pc : 32'h0;
      e_inst = e_pv ? mq[0].inst : 32'h0;
`ifdef INST_QUEUE_BYPASS_EN
      if (mq.size() == 0 && pv) begin
         e_pv = 1'b1;
         e_pc = pc;
         e_inst = inst;
         thru = pr;
      end
`endif
      e_pop  = e_pv & pr;
      e_pr   = (mq.size() < D) | e_pop;
      e_push = pv & e_pr;
      obs_pv   = bus.pop_valid;
      obs_pr   = bus.push_ready;
      obs_pc   = bus.pop_pc;
      obs_inst = bus.pop_inst;
      obs_cnt  = int'(bus.count);
      chk("pop_valid",  64'(obs_pv),   64'(e_pv));
      chk("pop_pc",     64'(obs_pc),   64'(e_pc));
      chk("pop_inst",   64'(obs_inst), 64'(e_inst));
      chk("push_ready", 64'(obs_pr),   64'(e_pr));
      chk("count",      64'(obs_cnt),  64'(mq.size()));
      @(posedge clk);
      if (!r || f) begin
         mq.delete();
      end else begin
         if (e_pop) begin
            popped.push_back(e_pc);
            if (!thru) void'(mq.pop_front());
         end
         if (e_push && !thru) mq.push_back('{pc, inst});
      end
   endtask

   task automatic idle(input logic pr);
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, pr);
   endtask

   initial begin
      int n40;
      rst = 1'b0;
      flush = 1'b0;
      bus.push_valid = 1'b0;
      bus.push_pc = '0;
      bus.push_inst = '0;
      bus.pop_ready = 1'b0;
      repeat (2) @(posedge clk);

      // Reset state
      idle(1'b0);
      chk("rst_count", 64'(obs_cnt), 64'd0);
      chk("rst_push_ready", 64'(obs_pr), 64'd1);

      // Fill to DEPTH with ID stalled, then offer a fifth entry
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 32'(4 * i), 32'hA000 + 32'(i), 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h14, 32'hBEEF, 1'b0);
      chk("full_count", 64'(obs_cnt), 64'd4);
      chk("full_push_ready", 64'(obs_pr), 64'd0);
      chk("full_head_pc", 64'(obs_pc), 64'h0);

      // Push into a full queue with a simultaneous pop, then drain
      popped.delete();
      step(1'b1, 1'b0, 1'b1, 32'h10, 32'hA010, 1'b1);
      chk("fullpp_push_ready", 64'(obs_pr), 64'd1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("fullpp_count", 64'(obs_cnt), 64'd1);
      chk("fullpp_npop", 64'(popped.size()), 64'd5);
      for (int i = 0; i < 5 && i < popped.size(); i++)
         chk("fullpp_order", 64'(popped[i]), 64'(4 * i));
      idle(1'b0);
      chk("drained_count", 64'(obs_cnt), 64'd0);

      // Flush with a concurrent push: nothing survives
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 32'h20 + 32'(4 * i), 32'h13, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h40, 32'h4040, 1'b0);
      chk("flush_shows_head", 64'(obs_pc), 64'h20);
      idle(1'b0);
      chk("flush_count", 64'(obs_cnt), 64'd0);
      chk("flush_pop_valid", 64'(obs_pv), 64'd0);
      chk("flush_pop_inst", 64'(obs_inst), 64'd0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      n40 = 0;
      foreach (popped[i]) if (popped[i] == 32'h40) n40++;
      chk("flush_no_0x40", 64'(n40), 64'd0);

      // Reset mid-operation, then resume
      step(1'b1, 1'b0, 1'b1, 32'h60, 32'h1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h64, 32'h2, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h68, 32'h3, 1'b0);
      idle(1'b0);
      chk("midrst_count", 64'(obs_cnt), 64'd0);
      chk("midrst_pop_valid", 64'(obs_pv), 64'd0);
      chk("midrst_push_ready", 64'(obs_pr), 64'd1);
      popped.delete();
      step(1'b1, 1'b0, 1'b1, 32'h70, 32'h7, 1'b0);
      idle(1'b1);
      chk("resume_pop", 64'(popped.size() > 0 ? popped[0] : 32'hFFFF_FFFF), 64'h70);

`ifdef INST_QUEUE_BYPASS_EN
      // Pass-through of an empty queue
      idle(1'b0);
      step(1'b1, 1'b0, 1'b1, 32'h80, 32'h0000_0013, 1'b1);
      chk("byp_pop_valid", 64'(obs_pv), 64'd1);
      chk("byp_pop_pc", 64'(obs_pc), 64'h80);
      chk("byp_pop_inst", 64'(obs_inst), 64'h13);
      idle(1'b0);
      chk("byp_count", 64'(obs_cnt), 64'd0);
`endif

      // Stream 10 entries through so the pointers wrap repeatedly
      idle(1'b1);
      popped.delete();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 32'(4 * i), 32'hC000 + 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);
      chk("wrap_npop", 64'(popped.size()), 64'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         chk("wrap_order", 64'(popped[i]), 64'(4 * i));

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
              1'($urandom_range(0, 1)), $urandom, $urandom,
              ($urandom_range(0, 3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
- REQ-001 SHALL have parameter ADDR_W, default 32: instruction address width.
- REQ-002 SHALL have parameter INST_W, default 32: instruction word width.
- REQ-003 SHALL have parameter DEPTH, default 4: entry count, power of two, 2..16.
- REQ-004 SHALL have port clk  input  1: sole clock; all state updates on rising edge.
- REQ-005 SHALL have port rst  input  1: reset, synchronous, active-low.
- REQ-006 SHALL have port flush  input  1: branch interception; discards all entries.
- REQ-007 SHALL have port push_valid  input  1: IF offers an entry.
- REQ-008 SHALL have port push_pc  input  ADDR_W: PC of the offered instruction.
- REQ-009 SHALL have port push_inst  input  INST_W: offered instruction word.
- REQ-010 SHALL have port push_ready  output  1: queue accepts the entry this cycle.
- REQ-011 SHALL have port pop_valid  output  1: head entry presented to ID.
- REQ-012 SHALL have port pop_pc  output  ADDR_W: head PC.
- REQ-013 SHALL have port pop_inst  output  INST_W: head instruction.
- REQ-014 SHALL have port pop_ready  input  1: ID consumes the head this cycle (deasserted = ID stall).
- REQ-015 SHALL have port count  output  $clog2(DEPTH+1): number of valid entries.

Function
- REQ-016 SHALL be a circular FIFO: head/tail pointers of width $clog2(DEPTH) that wrap from DEPTH-1 to 0, plus a registered occupancy counter.
- REQ-017 SHALL define push = push_valid & push_ready and pop = pop_valid & pop_ready; both may fire in one cycle.
- REQ-018 SHALL drive push_ready = (count < DEPTH) | pop, with pop taken from the current cycle; a push into a full queue is therefore accepted only when a pop fires in the same cycle.
- REQ-019 SHALL drive pop_valid = (count != 0), except as extended by REQ-031.
- REQ-020 SHALL drive pop_pc/pop_inst from the head entry while pop_valid is high, and all-zero (bubble) while pop_valid is low.
- REQ-021 SHALL update count as follows on a clock edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- REQ-022 SHALL preserve FIFO order; on a simultaneous push and pop the tail is written and the head advances in the same edge.
- REQ-023 SHALL treat flush as highest priority: on the edge where flush=1, count=0 and head=tail=0, and any same-cycle push or pop is discarded.
- REQ-024 SHALL still combinationally show the pre-flush head in the cycle flush is asserted; the flush takes effect at the following edge.
- REQ-025 SHALL ignore pop_ready while empty and push_valid while not ready; neither may corrupt state.
- REQ-026 SHALL hold head outputs stable while pop_valid=1 and pop_ready=0.

Reset
- REQ-027 SHALL, on a rising edge with rst=0, set count=0 and head=tail=0, leaving pop_valid=0, pop_pc=0, pop_inst=0 and push_ready=1 in the following cycle.
- REQ-028 SHALL give reset priority over flush, push and pop; reset mid-operation discards all entries.
- REQ-029 SHALL NOT require the storage array to be reset; outputs are masked by REQ-020.

Configuration
- REQ-030 SHALL honour macro INST_QUEUE_BYPASS_EN.
- REQ-031 With INST_QUEUE_BYPASS_EN defined, SHALL apply the following when count=0 and push_valid=1: pop_valid=1, and pop_pc/pop_inst equal push_pc/push_inst combinationally. If pop_ready=1 in that cycle, the entry passes through without being stored and count stays 0; if pop_ready=0, the entry is written normally.
- REQ-032 Without INST_QUEUE_BYPASS_EN, SHALL have a minimum IF-to-ID latency of one cycle; an entry pushed at edge N is first visible on pop outputs after edge N.

Verification
- REQ-033 DEPTH=4, no bypass: push PCs 0x00,0x04,0x08,0x0C with pop_ready=0 -> count=4, push_ready=0, pop_pc=0x00; a fifth push_valid is not accepted.
- REQ-034 Full queue, push 0x10 with pop_ready=1 in the same cycle -> push_ready=1, count stays 4, pops return 0x04,0x08,0x0C,0x10 in order.
- REQ-035 Three entries queued, flush=1 with push_valid=1 (PC 0x40) -> next cycle count=0, pop_valid=0, pop_inst=0; 0x40 is never popped.
- REQ-036 rst=0 asserted with 2 entries and push_valid=1 -> next cycle count=0, pop_valid=0, push_ready=1; deasserting rst resumes normal operation.
- REQ-037 Bypass defined, empty queue, push PC 0x80 / inst 0x00000013 with pop_ready=1 -> same cycle pop_valid=1, pop_pc=0x80, pop_inst=0x00000013; count remains 0.
- REQ-038 Wrap: push and pop 10 entries (PC 0x00..0x24 step 4) through DEPTH=4 -> pops occur in order with no loss, and the pointers wrap at least twice.
